// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//    Bit-serial unsigned subtractor: diff = a - b - bin (mod 2^WIDTH),
//    one bit per clock, LSB first, with a registered borrow chain.
//
// Ports
//    clk    : system clock, rising-edge active
//    rst_n  : asynchronous active-low reset
//    start  : operation request, sampled only while idle
//    a, b   : minuend / subtrahend, captured when start is accepted
//    bin    : borrow-in, captured when start is accepted
//    busy   : high while bits are being shifted through
//    done   : one-cycle pulse, diff/bout hold the new result
//    diff   : last completed difference (held until the next completion)
//    bout   : last completed borrow-out (1 iff a < b + bin)
// ---------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_sh_reg, diff_reg;
   logic             borrow_reg, bout_reg;
   logic [CW-1:0]    count_reg;

   logic             a0, b0, d, nb, last;
   logic [WIDTH-1:0] res_shifted;

   // Full-subtractor step on the current operand LSBs and borrow.
   assign a0   = a_sh_reg[0];
   assign b0   = b_sh_reg[0];
   assign d    = a0 ^ b0 ^ borrow_reg;
   assign nb   = (~a0 & b0) | (~(a0 ^ b0) & borrow_reg);
   assign last = (count_reg == CW'(WIDTH - 1));

   // Result fills from the MSB end, so after WIDTH shifts bit 0 holds the
   // first (LSB) difference bit.
   generate
      if (WIDTH == 1) begin : g_res_one
         assign res_shifted = d;
      end else begin : g_res_multi
         assign res_shifted = {d, res_sh_reg[WIDTH-1:1]};
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (last)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         SHIFT:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign diff = diff_reg;
   assign bout = bout_reg;

   // Datapath: operand capture, serial shifting and result publication.
   // diff/bout are only written on the final shift so they hold the previous
   // result throughout a following operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         res_sh_reg <= '0;
         borrow_reg <= 1'b0;
         count_reg  <= '0;
         diff_reg   <= '0;
         bout_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_sh_reg   <= a;
                  b_sh_reg   <= b;
                  borrow_reg <= bin;
                  count_reg  <= '0;
               end
            end
            SHIFT: begin
               a_sh_reg   <= a_sh_reg >> 1;
               b_sh_reg   <= b_sh_reg >> 1;
               res_sh_reg <= res_shifted;
               borrow_reg <= nb;
               count_reg  <= count_reg + 1'b1;
               if (last) begin
                  diff_reg <= res_shifted;
                  bout_reg <= nb;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//    Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.
//    The driver pushes the arithmetic result of each accepted operation into
//    a per-instance queue; a monitor pops and compares on every done pulse,
//    and checks that results hold between completions.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

   typedef struct {
      logic [31:0] diff;
      logic        bout;
      int          cyc;
   } entry_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   int         cyc = 0;

   logic       start8 = 1'b0, bin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, bout8;
   logic [7:0] diff8;

   logic       start1 = 1'b0, bin1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       busy1, done1, bout1;
   logic [0:0] diff1;

   entry_t     q8[$], q1[$];
   int         checks = 0, failures = 0;
   int         issued8 = 0, issued1 = 0, ndone8 = 0, ndone1 = 0;
   logic [31:0] hold_diff8 = '0, hold_diff1 = '0;
   logic        hold_bout8 = 1'b0, hold_bout1 = 1'b0;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
      .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain unsigned arithmetic on w-bit operands.
   function automatic void model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic bin, output logic [31:0] d, output logic bo);
      int mask, aa, bb, r;
      mask = (1 << w) - 1;
      aa   = int'(a) & mask;
      bb   = int'(b) & mask;
      r    = aa - bb - int'(bin);
      d    = 32'(r & mask);
      bo   = (aa < bb + int'(bin));
   endfunction

   function automatic void push(input bit one, input logic [7:0] a, input logic [7:0] b,
                                input logic bin);
      entry_t e;
      model(one ? 1 : 8, a, b, bin, e.diff, e.bout);
      e.cyc = cyc;
      if (one) begin q1.push_back(e); issued1++; end
      else     begin q8.push_back(e); issued8++; end
   endfunction

   // Single operation: drive start for one cycle (called just after an edge),
   // scramble inputs after capture, count busy cycles, return just after the
   // edge where the block is back in IDLE.
   task automatic op(input bit one, input logic [7:0] a, input logic [7:0] b, input logic bin);
      int w, nbusy;
      w = one ? 1 : 8;
      nbusy = 0;
      if (one) begin start1 = 1'b1; a1 = a[0:0]; b1 = b[0:0]; bin1 = bin; end
      else     begin start8 = 1'b1; a8 = a;      b8 = b;      bin8 = bin; end
      @(posedge clk); #1;
      push(one, a, b, bin);
      start1 = 1'b0; start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
      for (int i = 0; i <= w; i++) begin
         nbusy += one ? int'(busy1) : int'(busy8);
         @(posedge clk); #1;
      end
      chk(one ? "busy_cycles1" : "busy_cycles8", 32'(nbusy), 32'(w));
   endtask

   // Monitor: compare on done, otherwise the result must hold.
   always @(negedge clk) begin
      entry_t e;
      if (!rst_n) begin
         hold_diff8 = '0; hold_bout8 = 1'b0;
         hold_diff1 = '0; hold_bout1 = 1'b0;
      end else begin
         if (done8) begin
            ndone8++;
            if (q8.size() == 0) begin
               chk("spurious_done8", 32'(ndone8), 32'(issued8));
            end else begin
               e = q8.pop_front();
               chk("diff8", 32'(diff8), e.diff);
               chk("bout8", 32'(bout8), 32'(e.bout));
               chk("latency8", 32'(cyc - e.cyc), 32'd8);
               hold_diff8 = e.diff; hold_bout8 = e.bout;
            end
         end else begin
            chk("hold_diff8", 32'(diff8), hold_diff8);
            chk("hold_bout8", 32'(bout8), 32'(hold_bout8));
         end
         if (done1) begin
            ndone1++;
            if (q1.size() == 0) begin
               chk("spurious_done1", 32'(ndone1), 32'(issued1));
            end else begin
               e = q1.pop_front();
               chk("diff1", 32'(diff1), e.diff);
               chk("bout1", 32'(bout1), 32'(e.bout));
               chk("latency1", 32'(cyc - e.cyc), 32'd1);
               hold_diff1 = e.diff; hold_bout1 = e.bout;
            end
         end else begin
            chk("hold_diff1", 32'(diff1), hold_diff1);
            chk("hold_bout1", 32'(bout1), 32'(hold_bout1));
         end
      end
   end

   initial begin
      logic [7:0] pa[4] = '{8'h12, 8'hF0, 8'h03, 8'h80};
      logic [7:0] pb[4] = '{8'h34, 8'h0F, 8'h03, 8'h7F};
      logic       pc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_diff", 32'(diff8), 32'd0);
      chk("rst_bout", 32'(bout8), 32'd0);
      @(negedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed operations
      op(0, 8'h5A, 8'h3C, 1'b0);
      op(0, 8'h00, 8'h01, 1'b0);
      op(0, 8'h10, 8'h0F, 1'b1);

      // Start while busy is ignored
      start8 = 1'b1; a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
      @(posedge clk); #1;
      push(0, 8'h80, 8'h01, 1'b0);
      start8 = 1'b0;
      repeat (2) @(posedge clk);
      #1 start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      @(posedge clk); #1 start8 = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      repeat (4) @(posedge clk);
      #1;
      chk("ignored_start_dones", 32'(ndone8), 32'(issued8));

      // Asynchronous reset mid-operation
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0;
      @(posedge clk); #1 start8 = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy8), 32'd0);
      chk("abort_done", 32'(done8), 32'd0);
      chk("abort_diff", 32'(diff8), 32'd0);
      chk("abort_bout", 32'(bout8), 32'd0);
      @(negedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      op(0, 8'h09, 8'h03, 1'b0);

      // Start held high: one accept every WIDTH+2 cycles
      start8 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a8 = pa[k]; b8 = pb[k]; bin8 = pc[k];
         @(posedge clk); #1;
         push(0, pa[k], pb[k], pc[k]);
         a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
         repeat (9) @(posedge clk);
         #1;
      end
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // WIDTH=1 truth table
      for (int v = 0; v < 8; v++) begin
         logic [2:0] vv;
         vv = 3'(v);
         op(1, {7'd0, vv[2]}, {7'd0, vv[1]}, vv[0]);
      end

      // Random sweep at WIDTH=8
      for (int n = 0; n < 1000; n++) begin
         op(0, 8'($urandom), 8'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      repeat (4) @(posedge clk);
      #1;
      chk("pending8", 32'(q8.size()), 32'd0);
      chk("pending1", 32'(q1.size()), 32'd0);
      chk("done_count8", 32'(ndone8), 32'(issued8));
      chk("done_count1", 32'(ndone1), 32'(issued1));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b - bin, one bit per clock, LSB first.
- Each step uses full-subtractor logic (difference/borrow) with a registered borrow chain.
- It is the inverse-arithmetic counterpart to the combinational full adder.
- Sits beside the adder datapath as a low-area arithmetic unit, with a start/done handshake toward the controlling logic.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk  input  1  single system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bin  input  1  borrow-in; captured on accepted start
busy  output  1  high while an operation is in progress (SHIFT state)
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  result a - b - bin mod 2^WIDTH
bout  output  1  final borrow; 1 iff a < b + bin (unsigned)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0; internal shift registers, borrow and counter cleared.
- Reset asserted mid-operation aborts immediately and the result is discarded. After reset release, the block is in IDLE and accepts start on the next edge.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: latch a, b into operand shift registers, borrow<=bin, count<=0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one bit per edge, taking a0, b0 as operand LSBs and br as the current borrow:
  - d = a0 ^ b0 ^ br
  - nb = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d shifts into the MSB of the internal result register (right shift); operands shift right; borrow<=nb; count++.
  - After the WIDTH-th shift (edge E0+WIDTH): diff<=completed result, bout<=final nb, go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally back to IDLE.
- Latency: start sampled at E0; busy high from E0 to E0+WIDTH; done high in the cycle after E0+WIDTH. Total WIDTH+1 cycles to done, with WIDTH+2 cycles between accepted starts.
- Output stability: diff and bout change only at the completion edge, and otherwise hold the last result, including during a following operation and in IDLE.
- start while busy or in DONE: ignored, with no queuing. Inputs a, b, bin may change freely after capture without affecting the result.
- start held high continuously: a new operation is accepted on each return to IDLE.
- Arithmetic: unsigned, modulo 2^WIDTH; bout equals the borrow out of the MSB.
- WIDTH=1: the block reduces to a registered full subtractor.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start one cycle -> busy high for 8 cycles; done pulse 9 cycles after start edge; diff=0x1E, bout=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
- Issue a=0x80, b=0x01; pulse start again 3 cycles later with a=0xFF, b=0xFF -> second start ignored; diff=0x7F, bout=0; exactly one done pulse; diff holds 0x7F afterwards.
- Start a=0xAA, b=0x55; assert rst_n=0 asynchronously after 4 shifts -> busy, done, diff, bout all 0 immediately. After release, a=0x09, b=0x03 -> diff=0x06, bout=0.
- start held high with alternating operand pairs -> new operation every WIDTH+2 cycles; each result correct.
- WIDTH=1, all 8 combinations of {a,b,bin} -> diff/bout match the full-subtractor truth table (e.g. 0,1,1 -> diff=0, bout=1); done after 2 cycles. WIDTH=8 random sweep of 1000 vectors vs. reference model -> zero mismatches.
